relu_max_pool: RTL and testbench
================================

// Module: relu_max_pool
// PURPOSE
//  Streaming 1-D max-pool stage directly downstream of the ReLU forward stage.
//  Takes WIDTH-lane IEEE-754 single vectors and keeps a running per-lane max over
//  POOL consecutive accepted vectors. Emits one pooled vector per window through
//  a valid/ready output register. Full throughput: one input vector per cycle.
// PARAMETERS
//  WIDTH  4  lanes per vector (matches the ReLU stage width)
//  POOL   2  vectors per pooling window (>=1); CW = (POOL>1) ? $clog2(POOL) : 1
// PORTS
//  clk        in   1           clock, all state on rising edge
//  reset      in   1           asynchronous, active-high reset
//  clk_en     in   1           clock enable; when 0 all state holds, in_ready=0
//  in_valid   in   1           input vector valid
//  in_ready   out  1           stage can accept input this cycle
//  in_last    in   1           marks final vector of a row; closes a partial window
//  in_data    in   32xWIDTH    input floats [31:0] in_data [WIDTH-1:0]
//  out_valid  out  1           pooled vector valid
//  out_ready  in   1           downstream accepts out_data this cycle
//  out_data   out  32xWIDTH    pooled floats [31:0] out_data [WIDTH-1:0]
//  out_index  out  CWxWIDTH    per-lane argmax position in window (RELU_POOL_INDEX_EN only)
// BEHAVIOUR
//  - Reset: count=0, acc=0, out_valid=0, out_data=0, out_index=0. Reset mid-window
//    discards the partial window and any held output; no output is emitted for it.
//  - in_ready = clk_en & (~out_valid | out_ready). Accept = in_valid & in_ready.
//  - Compare: sign-magnitude order on raw bits. key = bit31 ? ~{bit31,mag} : {1,mag}
//    (unsigned compare of keys). +0 and -0 compare equal. Ties keep earlier value.
//    NaNs ordered by raw bits (no special handling; not produced upstream).
//  - count (CW bits) = beats accepted in current window.
//  - On accept with count==0: acc[i] <= in_data[i], idx[i] <= 0.
//  - On accept with count>0: acc[i] <= max(acc[i], in_data[i]); idx[i] updated
//    to count only if in_data[i] strictly greater.
//  - Window closes on accept when count==POOL-1 OR in_last=1: out_data <= final
//    max (including current beat), out_index <= final idx, out_valid <= 1,
//    count <= 0. Otherwise count <= count+1.
//  - Latency: out_valid rises the cycle after the closing beat's accepting edge.
//  - out_valid clears on out_ready & clk_en unless a new window closes on the
//    same edge (then out_data reloads, out_valid stays 1: back-to-back windows).
//  - out_data/out_index stable while out_valid & ~out_ready.
//  - POOL=1: every accepted beat closes a window; registered pass-through, 1 cycle.
//  - in_last with count==0: single-beat window, emitted as-is.
//  - clk_en=0: no accept, no output pop, all registers hold.
// CONFIGURATION
//  RELU_POOL_INDEX_EN defined: idx registers built; out_index carries per-lane
//   argmax (0..POOL-1) for the backward pass.
//  Not defined: idx logic omitted, out_index tied to 0; out_data identical.
// TESTING
//  1 POOL=2, lane0 beats 3F800000,40000000 -> out_data[0]=40000000, idx=1, 1 cyc later.
//  2 POOL=2, lane0 BF800000 then 3F000000 -> 3F000000; 80000000 then 00000000 -> 80000000, idx=0 (tie).
//  3 POOL=4, in_last on 2nd beat (3F800000,3F000000) -> out 3F800000 idx 0; next window count restarts.
//  4 out_ready=0 for 5 cycles with continuous in_valid -> in_ready=0 after next close,
//    out_data stable, no beat lost; release -> windows in order, 1 per POOL beats.
//  5 reset pulsed after 1 beat of a POOL=2 window -> out_valid=0, next 2 beats pooled fresh.
//  6 clk_en=0 mid-window for 3 cycles -> in_ready=0, state frozen, result unchanged.

Source files
------------

// File: rtl/relu_max_pool.sv
// Streaming per-lane max-pool over POOL accepted vectors, one pooled vector per window.
// Optional define RELU_POOL_INDEX_EN builds per-lane argmax tracking on out_index.
`timescale 1ns/1ps
module relu_max_pool #(
  parameter int WIDTH = 4,
  parameter int POOL  = 2,
  localparam int CW   = (POOL > 1) ? $clog2(POOL) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk_en,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic [31:0]   in_data   [WIDTH-1:0],
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data  [WIDTH-1:0],
  output logic [CW-1:0] out_index [WIDTH-1:0]
);

  logic [CW-1:0] count_reg;
  logic [31:0]   acc_reg  [WIDTH-1:0];
  logic [31:0]   acc_next [WIDTH-1:0];
  logic          take_new [WIDTH-1:0];
  logic          out_valid_reg;
  logic          accept;
  logic          close_win;
  logic          pop;

  // Sign-magnitude ordering key; negatives invert so larger magnitude sorts lower.
  function automatic logic [31:0] order_key(input logic [31:0] f);
    return f[31] ? ~{1'b1, f[30:0]} : {1'b1, f[30:0]};
  endfunction

  function automatic logic greater(input logic [31:0] a, input logic [31:0] b);
    if (a[30:0] == 31'd0 && b[30:0] == 31'd0)
      return 1'b0;
    return order_key(a) > order_key(b);
  endfunction

  assign out_valid = out_valid_reg;
  assign in_ready  = clk_en & (~out_valid_reg | out_ready);
  assign accept    = in_valid & in_ready;
  assign close_win = (count_reg == CW'(POOL - 1)) | in_last;
  assign pop       = clk_en & out_ready & out_valid_reg;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_lane
      assign take_new[gi] = (count_reg == '0) | greater(in_data[gi], acc_reg[gi]);
      assign acc_next[gi] = take_new[gi] ? in_data[gi] : acc_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg     <= '0;
      out_valid_reg <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        acc_reg[i]  <= '0;
        out_data[i] <= '0;
      end
    end else begin
      if (accept) begin
        for (int i = 0; i < WIDTH; i++)
          acc_reg[i] <= acc_next[i];
        if (close_win) begin
          count_reg <= '0;
          for (int i = 0; i < WIDTH; i++)
            out_data[i] <= acc_next[i];
        end else begin
          count_reg <= count_reg + CW'(1);
        end
      end
      // A window closing on the same edge as a pop keeps the output valid.
      if (accept && close_win)
        out_valid_reg <= 1'b1;
      else if (pop)
        out_valid_reg <= 1'b0;
    end
  end

`ifdef RELU_POOL_INDEX_EN
  logic [CW-1:0] idx_reg  [WIDTH-1:0];
  logic [CW-1:0] idx_next [WIDTH-1:0];

  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_idx
      assign idx_next[gi] = (count_reg == '0) ? '0 :
                            (take_new[gi] ? count_reg : idx_reg[gi]);
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        idx_reg[i]   <= '0;
        out_index[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < WIDTH; i++)
        idx_reg[i] <= idx_next[i];
      if (close_win)
        for (int i = 0; i < WIDTH; i++)
          out_index[i] <= idx_next[i];
    end
  end
`else
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_idx_tie
      assign out_index[gi] = '0;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_relu_max_pool.sv
// Scoreboarded bench for relu_max_pool with POOL=2, POOL=4 and POOL=1 instances fed in parallel.
`timescale 1ns/1ps
module tb_relu_max_pool;

  typedef struct packed {
    logic [127:0] d;
    logic [7:0]   ix;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clk_en = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_data [3:0];

  logic        ir_a, ir_b, ir_c, ov_a, ov_b, ov_c;
  logic [31:0] od_a [3:0];
  logic [31:0] od_b [3:0];
  logic [31:0] od_c [3:0];
  logic [0:0]  oi_a [3:0];
  logic [1:0]  oi_b [3:0];
  logic [0:0]  oi_c [3:0];

  logic [127:0] od [3];
  logic [7:0]   oi [3];
  logic         ov [3];
  logic         ir [3];

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   pool [3] = '{2, 4, 1};
  int   m_cnt [3];
  logic [31:0] m_acc [3][4];
  int   m_idx [3][4];

  always #5 clk = ~clk;

  relu_max_pool #(.WIDTH(4), .POOL(2)) u_a (
    .clk(clk), .reset(reset), .clk_en(clk_en), .in_valid(in_valid), .in_ready(ir_a),
    .in_last(in_last), .in_data(in_data), .out_valid(ov_a), .out_ready(out_ready),
    .out_data(od_a), .out_index(oi_a));
  relu_max_pool #(.WIDTH(4), .POOL(4)) u_b (
    .clk(clk), .reset(reset), .clk_en(clk_en), .in_valid(in_valid), .in_ready(ir_b),
    .in_last(in_last), .in_data(in_data), .out_valid(ov_b), .out_ready(out_ready),
    .out_data(od_b), .out_index(oi_b));
  relu_max_pool #(.WIDTH(4), .POOL(1)) u_c (
    .clk(clk), .reset(reset), .clk_en(clk_en), .in_valid(in_valid), .in_ready(ir_c),
    .in_last(in_last), .in_data(in_data), .out_valid(ov_c), .out_ready(out_ready),
    .out_data(od_c), .out_index(oi_c));

  assign od[0] = {od_a[3], od_a[2], od_a[1], od_a[0]};
  assign od[1] = {od_b[3], od_b[2], od_b[1], od_b[0]};
  assign od[2] = {od_c[3], od_c[2], od_c[1], od_c[0]};
  assign oi[0] = {1'b0, oi_a[3], 1'b0, oi_a[2], 1'b0, oi_a[1], 1'b0, oi_a[0]};
  assign oi[1] = {oi_b[3], oi_b[2], oi_b[1], oi_b[0]};
  assign oi[2] = {1'b0, oi_c[3], 1'b0, oi_c[2], 1'b0, oi_c[1], 1'b0, oi_c[0]};
  assign ov[0] = ov_a;
  assign ov[1] = ov_b;
  assign ov[2] = ov_c;
  assign ir[0] = ir_a;
  assign ir[1] = ir_b;
  assign ir[2] = ir_c;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Independent reference ordering: decode the float to a real value.
  function automatic real f2r(input logic [31:0] f);
    real m;
    int  e;
    e = int'(f[30:23]);
    m = real'(f[22:0]) / 8388608.0;
    if (e == 0) m = m * (2.0 ** (-126));
    else        m = (1.0 + m) * (2.0 ** (e - 127));
    return f[31] ? -m : m;
  endfunction

  function automatic int qsize(input int k);
    if (k == 0) return qa.size();
    if (k == 1) return qb.size();
    return qc.size();
  endfunction

  function automatic exp_t qfront(input int k);
    if (k == 0) return qa[0];
    if (k == 1) return qb[0];
    return qc[0];
  endfunction

  task automatic qpush(input int k, input exp_t e);
    if (k == 0)      qa.push_back(e);
    else if (k == 1) qb.push_back(e);
    else             qc.push_back(e);
  endtask

  task automatic qpop(input int k);
    exp_t e;
    if (k == 0)      e = qa.pop_front();
    else if (k == 1) e = qb.pop_front();
    else             e = qc.pop_front();
  endtask

  task automatic model_accept(input int k, input bit last);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (m_cnt[k] == 0) begin
        m_acc[k][i] = in_data[i];
        m_idx[k][i] = 0;
      end else if (f2r(in_data[i]) > f2r(m_acc[k][i])) begin
        m_acc[k][i] = in_data[i];
        m_idx[k][i] = m_cnt[k];
      end
    end
    if (m_cnt[k] == pool[k] - 1 || last) begin
      e.d = {m_acc[k][3], m_acc[k][2], m_acc[k][1], m_acc[k][0]};
`ifdef RELU_POOL_INDEX_EN
      e.ix = {2'(m_idx[k][3]), 2'(m_idx[k][2]), 2'(m_idx[k][1]), 2'(m_idx[k][0])};
`else
      e.ix = 8'd0;
`endif
      qpush(k, e);
      m_cnt[k] = 0;
    end else begin
      m_cnt[k]++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_out_valid P%0d", pool[k]), 128'(ov[k]), 128'd0);
      chk($sformatf("reset_out_data P%0d", pool[k]), od[k], 128'd0);
      chk($sformatf("reset_out_index P%0d", pool[k]), 128'(oi[k]), 128'd0);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    qa.delete();
    qb.delete();
    qc.delete();
    for (int k = 0; k < 3; k++) m_cnt[k] = 0;
  endtask

  // One clock of stimulus: check outputs against the scoreboard, then advance the model.
  task automatic cy(input bit v, input bit last, input logic [31:0] d3, input logic [31:0] d2,
                    input logic [31:0] d1, input logic [31:0] d0, input bit ordy, input bit en);
    bit   acc_f [3];
    bit   pop_f [3];
    bit   rdy;
    exp_t e;
    in_valid = v; in_last = last; out_ready = ordy; clk_en = en;
    in_data[0] = d0; in_data[1] = d1; in_data[2] = d2; in_data[3] = d3;
    #1;
    for (int k = 0; k < 3; k++) begin
      rdy = en & ((qsize(k) == 0) | ordy);
      chk($sformatf("in_ready P%0d", pool[k]), 128'(ir[k]), 128'(rdy));
      chk($sformatf("out_valid P%0d", pool[k]), 128'(ov[k]), 128'(qsize(k) != 0));
      if (qsize(k) != 0) begin
        e = qfront(k);
        chk($sformatf("out_data P%0d", pool[k]), od[k], e.d);
        chk($sformatf("out_index P%0d", pool[k]), 128'(oi[k]), 128'(e.ix));
      end
      acc_f[k] = v & rdy;
      pop_f[k] = en & ordy & (qsize(k) != 0);
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (pop_f[k]) qpop(k);
      if (acc_f[k]) model_accept(k, last);
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rf();
    logic s;
    s = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 7) == 0) return {s, 31'd0};
    return {s, 8'($urandom_range(100, 154)), 23'($urandom)};
  endfunction

  initial begin
    for (int i = 0; i < 4; i++) in_data[i] = 32'd0;
    do_reset();

    // Basic pooling: larger value wins in lane0, mixed signs in other lanes.
    cy(1, 0, 32'h41200000, 32'h00000000, 32'hC0000000, 32'h3F800000, 1, 1);
    cy(1, 0, 32'h41100000, 32'h80000000, 32'h3F800000, 32'h40000000, 1, 1);
    cy(0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 1);

    // Negative vs positive, then signed-zero tie keeps the earlier value.
    cy(1, 0, 32'hC1000000, 32'h3F800000, 32'h40400000, 32'hBF800000, 1, 1);
    cy(1, 0, 32'hC0000000, 32'h3F800000, 32'h40400001, 32'h3F000000, 1, 1);
    cy(1, 0, 32'h3F800000, 32'hBF800000, 32'h00000000, 32'h80000000, 1, 1);
    cy(1, 0, 32'h3F800000, 32'hBF000000, 32'h80000000, 32'h00000000, 1, 1);
    cy(0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 1);

    // in_last closes a partial window; next window restarts from zero count.
    cy(1, 0, 32'h40000000, 32'h3F800000, 32'hBF800000, 32'h3F800000, 1, 1);
    cy(1, 1, 32'h40400000, 32'h3F800000, 32'hC0000000, 32'h3F000000, 1, 1);
    cy(1, 1, 32'hBF800000, 32'h3E800000, 32'h40800000, 32'h40A00000, 1, 1);
    for (int j = 0; j < 4; j++)
      cy(1, 0, 32'h3F800000 + 32'(j), 32'h40000000 - 32'(j), 32'hC0000000 + 32'(j), 32'(j) << 20, 1, 1);

    // Backpressure with continuous input, then release.
    for (int j = 0; j < 5; j++)
      cy(1, 0, 32'h41000000 + 32'(j), 32'hBF800000 - 32'(j), 32'h3F800000 + 32'(j << 4), 32'h40000000 + 32'(j << 8), 0, 1);
    for (int j = 0; j < 8; j++)
      cy(1, 0, 32'h40000000 + 32'(j), 32'hC0400000 + 32'(j), 32'h3F000000 + 32'(j << 12), 32'h3F800000 - 32'(j), 1, 1);
    cy(0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 1);
    cy(0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 1);

    // Reset mid-window discards the partial window.
    cy(1, 0, 32'h42000000, 32'h42000000, 32'h42000000, 32'h42000000, 1, 1);
    do_reset();
    cy(1, 0, 32'h3F800000, 32'hBF800000, 32'h3E000000, 32'h3F000000, 1, 1);
    cy(1, 0, 32'h3F000000, 32'hBF000000, 32'h3E800000, 32'h3E800000, 1, 1);
    cy(0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 1);

    // Clock enable low mid-window freezes everything.
    cy(1, 0, 32'h3F800000, 32'h40000000, 32'hBF800000, 32'h40400000, 1, 1);
    for (int j = 0; j < 3; j++)
      cy(1, 0, 32'h47000000, 32'h47000000, 32'h47000000, 32'h47000000, 1, 0);
    cy(1, 0, 32'h3F000000, 32'h40400000, 32'hBF000000, 32'h40000000, 1, 1);
    cy(0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 1);
    cy(0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 1);

    // Randomized traffic with mixed valid, last, ready and enable.
    for (int j = 0; j < 80; j++)
      cy($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, rf(), rf(), rf(), rf(),
         $urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0);
    for (int j = 0; j < 4; j++)
      cy(0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
